// File: rtl/sketch_counter_update.sv
// One count-min sketch row: saturating counters indexed by hash LSBs, with a
// forwarding update pipeline, a low-priority query port, a clear sweep and stats.
module sketch_counter_update #(
  parameter int TDATA_WIDTH = 32,
  parameter int IDX_W       = 10,
  parameter int CNT_W       = 16
) (
  input  logic                   memclk,
  input  logic                   reset,
  input  logic                   din_inc,
  input  logic [TDATA_WIDTH-1:0] universal_data,
  input  logic                   clear_req,
  input  logic                   query_valid,
  input  logic [IDX_W-1:0]       query_idx,
  output logic                   query_ready,
  output logic                   query_data_valid,
  output logic [CNT_W-1:0]       query_data,
  output logic                   busy,
  output logic [31:0]            total_count,
  output logic [31:0]            sat_count,
  output logic [31:0]            drop_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? CNT_MAX : val + CNT_W'(1);
  endfunction

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_addr, sweep_addr_nxt;

  logic             accept, q_accept, drop;
  logic             rd_en, wr_en;
  logic [IDX_W-1:0] rd_addr, wr_addr;
  logic [CNT_W-1:0] wr_data, ram_q;
  logic [CNT_W-1:0] mem [0:(1<<IDX_W)-1];

  logic             vld_p1, fwd_vld_p1, qv_p1;
  logic [IDX_W-1:0] idx_p1, fwd_addr_p1;
  logic [CNT_W-1:0] fwd_data_p1, old_p1, new_p1;

  logic             unused_hash;
  assign unused_hash = ^universal_data[TDATA_WIDTH-1:IDX_W];

  assign accept      = din_inc && (state == RUN) && !clear_req;
  assign drop        = din_inc && (state == CLEAR) && !clear_req;
  assign query_ready = (state == RUN) && !din_inc && !clear_req;
  assign q_accept    = query_valid && query_ready;
  assign busy        = (state == CLEAR);

  always_comb begin
    state_nxt      = state;
    sweep_addr_nxt = sweep_addr;
    if (clear_req) begin
      state_nxt      = CLEAR;
      sweep_addr_nxt = '0;
    end else if (state == CLEAR) begin
      sweep_addr_nxt = sweep_addr + IDX_W'(1);
      if (sweep_addr == IDX_LAST) state_nxt = RUN;
    end
  end

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_addr_nxt;
    end
  end

  // Read port: updates win over queries; the sweep only writes.
  assign rd_en   = accept || q_accept;
  assign rd_addr = accept ? universal_data[IDX_W-1:0] : query_idx;

  // Sweep and S1 writes never coincide: S1 is only loaded while staying in RUN.
  assign wr_en   = (state == CLEAR) || vld_p1;
  assign wr_addr = (state == CLEAR) ? sweep_addr : idx_p1;
  assign wr_data = (state == CLEAR) ? '0 : new_p1;

  always_ff @(posedge memclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  // ---- stage p0 -> p1: index capture, RAM read, last-write tracking ----
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      fwd_vld_p1 <= 1'b0;
      qv_p1      <= 1'b0;
    end else begin
      vld_p1     <= accept;
      fwd_vld_p1 <= wr_en;
      qv_p1      <= q_accept;
    end
  end

  always_ff @(posedge memclk) begin
    if (accept) idx_p1 <= universal_data[IDX_W-1:0];
    fwd_addr_p1 <= wr_addr;
    fwd_data_p1 <= wr_data;
  end

  // The read-first RAM misses the write landing on the capture edge, so forward it.
  assign old_p1 = (fwd_vld_p1 && (fwd_addr_p1 == idx_p1)) ? fwd_data_p1 : ram_q;
  assign new_p1 = sat_inc(old_p1);

  // ---- stage p1 -> p2: query result and statistics ----
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      query_data_valid <= 1'b0;
      query_data       <= '0;
      total_count      <= '0;
      sat_count        <= '0;
      drop_count       <= '0;
    end else begin
      query_data_valid <= qv_p1;
      if (qv_p1) query_data <= ram_q;
      if (clear_req) begin
        total_count <= '0;
        sat_count   <= '0;
        drop_count  <= '0;
      end else begin
        if (accept) total_count <= total_count + 32'd1;
        if (vld_p1 && (old_p1 == CNT_MAX)) sat_count <= sat_count + 32'd1;
        if (drop) drop_count <= drop_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/sketch_counter_update.md
# sketch_counter_update

Count-min-style sketch row that consumes the hashed flow key (`universal_data`, qualified by `din_inc`) produced by the 5-tuple/universal-hash stage. Each valid hash increments a saturating counter in an on-chip table indexed by the hash LSBs. The block provides a low-priority query port for reading counters, a table-clear sweep, and running statistics. It sits directly downstream of the hash stage in the 200 MHz `memclk` domain.

## Interface
- `TDATA_WIDTH`, 32, width of incoming hash.
- `IDX_W`, 10, table index width; table depth 2^IDX_W; index = `universal_data[IDX_W-1:0]`.
- `CNT_W`, 16, counter width; saturates at 2^CNT_W-1.

- `memclk`  in  1  200 MHz clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din_inc`  in  1  hash valid strobe from the hash stage; one increment per high cycle.
- `universal_data`  in  TDATA_WIDTH  hash value.
- `clear_req`  in  1  one-cycle pulse; start table clear and zero stats.
- `query_valid`  in  1  query request.
- `query_idx`  in  IDX_W  counter address to read.
- `query_ready`  out  1  combinational; query accepted on an edge with `query_valid && query_ready`.
- `query_data_valid`  out  1  registered; one-cycle pulse.
- `query_data`  out  CNT_W  counter value; held until next query result.
- `busy`  out  1  high while clear sweep runs.
- `total_count`  out  32  accepted increments, wraps.
- `sat_count`  out  32  increments applied to an already-saturated counter, wraps.
- `drop_count`  out  32  `din_inc` cycles not accepted, wraps.

## Operation
- Storage: one simple dual-port RAM (1 sync read port, read-first; 1 write port), 2^IDX_W x CNT_W. Contents are not reset.
- FSM states: CLEAR, RUN. Async reset -> CLEAR, sweep address 0, all stats 0. CLEAR writes 0 to address k on the k-th edge in CLEAR, and goes to RUN after writing address 2^IDX_W-1. In RUN, `clear_req` -> CLEAR with sweep address 0. `clear_req` during CLEAR restarts the sweep at 0.
- Read-port priority: clear sweep (no read) > update > query. `query_ready` = state==RUN && !`din_inc` && !`clear_req`.
- Update pipeline: at acceptance edge E0 (`din_inc` && state==RUN && !`clear_req`), capture index into S1 and issue a RAM read. During the following cycle, S1 computes `new` = (`old` == max) ? max : `old`+1. RAM write occurs at E1. `total_count`+1 at E0. `sat_count`+1 at E1 if `old` == max.
- Hazard forwarding: if S1 index equals the index written at the immediately preceding edge, `old` = that forwarded write value, not the RAM output. Back-to-back same-index increments must all count.
- Drops: `din_inc` in CLEAR or coincident with `clear_req` -> not applied; `drop_count`+1.
- Clear acceptance zeroes `total_count`, `sat_count` and `drop_count` at that edge. A coincident drop is not counted. An S1 write pending at that edge still completes, then is overwritten by the sweep.
- Query: accepted at edge Q. RAM read at Q. `query_data` and `query_data_valid` are registered at Q+1. The value reflects all updates written at or before edge Q-1.

## Timing
- Reset values: `busy`=1, `query_data_valid`=0, `query_data`=0, all stats=0, `query_ready`=0.
- Clear duration: 2^IDX_W cycles. `busy` deasserts registered on the edge that writes the last address. Increments are accepted starting on the next edge.
- Update latency: counter write 1 edge after acceptance; sustained throughput one increment per cycle.
- Query latency: result 1 edge after acceptance; at most one query accepted per cycle.
- Reset mid-operation: immediate return to reset values. Any pending S1 write is discarded. The sweep restarts.

## Test plan
- Reset, IDX_W=4: `busy`=1 for 16 cycles, then 0. Query every index -> `query_data`=0. Stats=0.
- 5 consecutive `din_inc` with hash 0x0000_0003, then query 3 -> 5 (forwarding path). Query 2 -> 0. `total_count`=5.
- CNT_W=4, 20 increments to index 7 -> query returns 15. `sat_count`=5.
- Alternating hashes 0x1, 0x11, 0x1 (IDX_W=4, both map to index 1) across 6 cycles -> index 1 = 6.
- `clear_req` while `din_inc` stays high for 20 cycles -> stats zeroed at clear. `drop_count`=16 after sweep (pulse edge excluded). Counts resume afterwards. All old counters read 0.
- `query_valid` held high with `din_inc` toggling -> queries are accepted only on cycles where `din_inc`=0. Each result arrives 1 cycle after acceptance.
